// File: rtl/ex_div.sv
// ============================================================================
//  Module   : ex_div
//  Brief    : Iterative 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU)
//             with direct register-file writeback. Optional macro
//             EX_DIV_EARLY_OUT_EN lets divide-by-zero and signed overflow
//             bypass the iteration loop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_start_i,
    input  logic [1:0]  div_op_i,
    input  logic [31:0] div_dividend_i,
    input  logic [31:0] div_divisor_i,
    input  logic [4:0]  div_rd_addr_i,
    input  logic        div_flush_i,
    output logic        div_busy_o,
    output logic [4:0]  div_rd_addr_o,
    output logic [31:0] div_rd_data_o,
    output logic        div_rd_wr_en_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0]  c_LAST_ITER = 6'd31;
    localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONES  = 32'hFFFF_FFFF;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] acc_q;
    logic [31:0] rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        dz_q;
    logic        ovf_q;
    logic        busy_q;
    logic        wr_en_q;
    logic [4:0]  rd_addr_q;
    logic [31:0] rd_data_q;

    // Operand decode on the incoming request (bit 0 of op selects unsigned).
    logic        w_in_signed;
    logic        w_in_dz;
    logic        w_in_ovf;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_early_out;

    assign w_in_signed = ~div_op_i[0];
    assign w_in_dz     = (div_divisor_i == 32'd0);
    assign w_in_ovf    = w_in_signed && (div_dividend_i == c_INT_MIN) &&
                         (div_divisor_i == c_ALL_ONES);
    assign w_a_neg     = w_in_signed & div_dividend_i[31];
    assign w_b_neg     = w_in_signed & div_divisor_i[31];
    assign w_a_mag     = w_a_neg ? (32'd0 - div_dividend_i) : div_dividend_i;
    assign w_b_mag     = w_b_neg ? (32'd0 - div_divisor_i)  : div_divisor_i;

`ifdef EX_DIV_EARLY_OUT_EN
    assign w_early_out = w_in_dz | w_in_ovf;
`else
    assign w_early_out = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the difference only if it did not borrow.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    assign w_shift = {rem_q, acc_q[31]};
    assign w_diff  = w_shift - {1'b0, dvs_q};
    assign w_ge    = ~w_diff[32];
    assign rem_d   = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign quo_d   = {acc_q[30:0], w_ge};

    function automatic logic [31:0] f_result(
        input logic [1:0]  op,
        input logic        dz,
        input logic        ovf,
        input logic        neg_quo,
        input logic        neg_rem,
        input logic [31:0] quo,
        input logic [31:0] rem,
        input logic [31:0] dvd
    );
        logic [31:0] q;
        logic [31:0] r;
        if (dz) begin
            q = c_ALL_ONES;
            r = dvd;
        end else if (ovf) begin
            q = c_INT_MIN;
            r = 32'd0;
        end else begin
            q = neg_quo ? (32'd0 - quo) : quo;
            r = neg_rem ? (32'd0 - rem) : rem;
        end
        return op[1] ? r : q;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 2'd0;
            rd_q      <= 5'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            acc_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_en_q   <= 1'b0;
                    rd_addr_q <= 5'd0;
                    rd_data_q <= 32'd0;
                    if (div_start_i && !div_flush_i) begin
                        op_q      <= div_op_i;
                        rd_q      <= div_rd_addr_i;
                        dvd_q     <= div_dividend_i;
                        dvs_q     <= w_b_mag;
                        acc_q     <= w_a_mag;
                        rem_q     <= 32'd0;
                        cnt_q     <= 6'd0;
                        neg_quo_q <= w_a_neg ^ w_b_neg;
                        neg_rem_q <= w_a_neg;
                        dz_q      <= w_in_dz;
                        ovf_q     <= w_in_ovf;
                        busy_q    <= 1'b1;
                        if (w_early_out) begin
                            state_q   <= S_DONE;
                            rd_addr_q <= div_rd_addr_i;
                            wr_en_q   <= (div_rd_addr_i != 5'd0);
                            rd_data_q <= f_result(div_op_i, w_in_dz, w_in_ovf,
                                                  1'b0, 1'b0, 32'd0, 32'd0,
                                                  div_dividend_i);
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (div_flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        acc_q <= quo_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == c_LAST_ITER) begin
                            state_q   <= S_DONE;
                            rd_addr_q <= rd_q;
                            wr_en_q   <= (rd_q != 5'd0);
                            rd_data_q <= f_result(op_q, dz_q, ovf_q, neg_quo_q,
                                                  neg_rem_q, quo_d, rem_d,
                                                  dvd_q);
                        end
                    end
                end

                S_DONE: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_addr_q <= 5'd0;
                    rd_data_q <= 32'd0;
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_addr_q <= 5'd0;
                    rd_data_q <= 32'd0;
                end
            endcase
        end
    end

    assign div_busy_o     = busy_q;
    assign div_rd_addr_o  = rd_addr_q;
    assign div_rd_data_o  = rd_data_q;
    // A flush arriving during the writeback cycle must squash the write.
    assign div_rd_wr_en_o = wr_en_q & ~div_flush_i;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
//  Module   : tb_ex_div
//  Brief    : Self-checking bench for ex_div: directed corner cases plus
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_div;

    logic        clk;
    logic        rst_n;
    logic        div_start_i;
    logic [1:0]  div_op_i;
    logic [31:0] div_dividend_i;
    logic [31:0] div_divisor_i;
    logic [4:0]  div_rd_addr_i;
    logic        div_flush_i;
    logic        div_busy_o;
    logic [4:0]  div_rd_addr_o;
    logic [31:0] div_rd_data_o;
    logic        div_rd_wr_en_o;

    int n_asserts = 0;
    int n_fail    = 0;

    ex_div dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .div_start_i    (div_start_i),
        .div_op_i       (div_op_i),
        .div_dividend_i (div_dividend_i),
        .div_divisor_i  (div_divisor_i),
        .div_rd_addr_i  (div_rd_addr_i),
        .div_flush_i    (div_flush_i),
        .div_busy_o     (div_busy_o),
        .div_rd_addr_o  (div_rd_addr_o),
        .div_rd_data_o  (div_rd_data_o),
        .div_rd_wr_en_o (div_rd_wr_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics expressed with native SV arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0])
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef EX_DIV_EARLY_OUT_EN
        return special ? 1 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    // Issues one operation (caller sits at a falling edge) and follows it to
    // retirement. lat = number of rising edges from the start edge to the
    // register-file write edge, i.e. the index of the last busy cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit intrude);
        int          lat;
        int          wcnt;
        logic [31:0] dsnap;
        logic [4:0]  asnap;
        div_op_i       = op;
        div_dividend_i = a;
        div_divisor_i  = b;
        div_rd_addr_i  = rd;
        div_start_i    = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0;
        lat   = 0;
        wcnt  = 0;
        dsnap = 32'd0;
        asnap = 5'd0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (intrude && n == 1) begin
                div_start_i    = 1'b1;
                div_op_i       = ~op;
                div_dividend_i = ~a;
                div_divisor_i  = b + 32'd1;
                div_rd_addr_i  = rd ^ 5'h1F;
            end
            if (intrude && n == 3) div_start_i = 1'b0;
            if (!div_busy_o) break;
            lat   = n;
            dsnap = div_rd_data_o;
            asnap = div_rd_addr_o;
            if (div_rd_wr_en_o) wcnt++;
        end
        div_start_i = 1'b0;
        check({tag, "/latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check({tag, "/data"}, dsnap, ref_result(op, a, b));
        check({tag, "/addr"}, {27'd0, asnap}, {27'd0, rd});
        check({tag, "/wr_count"}, 32'(wcnt), (rd != 5'd0) ? 32'd1 : 32'd0);
        check({tag, "/idle_outputs"},
              div_rd_data_o | {27'd0, div_rd_addr_o} | {31'd0, div_rd_wr_en_o}, 32'd0);
    endtask

    initial begin
        int          wcnt;
        int          bcnt;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rrd;

        rst_n          = 1'b0;
        div_start_i    = 1'b0;
        div_op_i       = 2'd0;
        div_dividend_i = 32'd0;
        div_divisor_i  = 32'd0;
        div_rd_addr_i  = 5'd0;
        div_flush_i    = 1'b0;
        #1;
        check("reset/busy",  {31'd0, div_busy_o}, 32'd0);
        check("reset/wr_en", {31'd0, div_rd_wr_en_o}, 32'd0);
        check("reset/addr",  {27'd0, div_rd_addr_o}, 32'd0);
        check("reset/data",  div_rd_data_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First start lands on the first rising edge after reset release.
        do_op("div_20_m3",  2'b00, 32'h0000_0014, 32'hFFFF_FFFD, 5'd5, 1'b0);
        do_op("rem_20_m3",  2'b10, 32'h0000_0014, 32'hFFFF_FFFD, 5'd5, 1'b0);
        do_op("divu_by0",   2'b01, 32'h1234_5678, 32'd0, 5'd7, 1'b0);
        do_op("remu_by0",   2'b11, 32'h1234_5678, 32'd0, 5'd8, 1'b0);
        do_op("div_by0",    2'b00, 32'h8765_4321, 32'd0, 5'd9, 1'b0);
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        do_op("divu_big",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        do_op("rem_neg",    2'b10, 32'hFFFF_FFEC, 32'h0000_0003, 5'd13, 1'b0);

        // Flush in the middle of CALC: busy drops next cycle, no write follows.
        div_op_i       = 2'b01;
        div_dividend_i = 32'd100;
        div_divisor_i  = 32'd7;
        div_rd_addr_i  = 5'd3;
        div_start_i    = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (9) @(negedge clk);
        div_flush_i = 1'b1;
        @(negedge clk);
        div_flush_i = 1'b0;
        check("flush_calc/busy", {31'd0, div_busy_o}, 32'd0);
        wcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_rd_wr_en_o) wcnt++;
        end
        check("flush_calc/no_write", 32'(wcnt), 32'd0);
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 1'b0);

        // Flush during the writeback cycle squashes the write enable.
        div_op_i       = 2'b01;
        div_dividend_i = 32'd1000;
        div_divisor_i  = 32'd10;
        div_rd_addr_i  = 5'd4;
        div_start_i    = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (32) @(negedge clk);
        check("flush_done/wr_before", {31'd0, div_rd_wr_en_o}, 32'd1);
        div_flush_i = 1'b1;
        #1;
        check("flush_done/wr_forced", {31'd0, div_rd_wr_en_o}, 32'd0);
        @(negedge clk);
        div_flush_i = 1'b0;
        check("flush_done/busy", {31'd0, div_busy_o}, 32'd0);

        // Start together with flush in IDLE is rejected.
        div_start_i = 1'b1;
        div_flush_i = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        check("start_flush/busy", {31'd0, div_busy_o}, 32'd0);

        do_op("divu_intrude", 2'b01, 32'd100, 32'd7, 5'd6, 1'b1);
        do_op("div_intrude",  2'b00, 32'hFFFF_FF00, 32'd9, 5'd14, 1'b1);
        do_op("div_rd0",      2'b00, 32'd50, 32'd5, 5'd0, 1'b0);

        // Asynchronous reset mid-CALC clears everything immediately.
        div_op_i       = 2'b00;
        div_dividend_i = 32'd12345;
        div_divisor_i  = 32'd17;
        div_rd_addr_i  = 5'd21;
        div_start_i    = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/busy",  {31'd0, div_busy_o}, 32'd0);
        check("rst_mid/wr_en", {31'd0, div_rd_wr_en_o}, 32'd0);
        check("rst_mid/addr",  {27'd0, div_rd_addr_o}, 32'd0);
        check("rst_mid/data",  div_rd_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wcnt = 0;
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_rd_wr_en_o) wcnt++;
            if (div_busy_o) bcnt++;
        end
        check("rst_mid/no_write", 32'(wcnt), 32'd0);
        check("rst_mid/no_busy",  32'(bcnt), 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op("random", rop, ra, rb, rrd, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous assert, active-low).
REQ-002 div_start_i  input  1  request a new divide; sampled only in IDLE.
REQ-003 div_op_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-004 div_dividend_i  input  32  rs1 operand; div_divisor_i  input  32  rs2 operand.
REQ-005 div_rd_addr_i  input  5  destination register index.
REQ-006 div_flush_i  input  1  abort the current operation (pipeline flush).
REQ-007 div_busy_o  output  1  high while an operation is accepted and not yet retired.
REQ-008 div_rd_addr_o  output  5; div_rd_data_o  output  32; div_rd_wr_en_o  output  1 -- writeback port, connected directly to the register-file rd write port.

Function
REQ-009 The block SHALL implement FSM states IDLE, CALC and DONE; reset state is IDLE.
REQ-010 In IDLE with div_start_i=1 and div_flush_i=0, the block SHALL latch op, operands and rd address, and enter CALC (or DONE, see REQ-020) on that edge; div_busy_o SHALL be high from the next cycle.
REQ-011 CALC SHALL run a restoring shift-subtract loop on 32-bit operand magnitudes, one quotient bit per cycle, for exactly 32 cycles, tracked by a 6-bit counter, then enter DONE.
REQ-012 DIV/REM SHALL use magnitudes of signed operands; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). DIVU/REMU SHALL treat operands as unsigned.
REQ-013 Divisor zero SHALL yield quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned ops.
REQ-014 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF) SHALL yield quotient 0x80000000 and remainder 0.
REQ-015 In DONE, for exactly one cycle, the block SHALL drive div_rd_data_o with the result, div_rd_addr_o with the latched rd, and div_rd_wr_en_o=1 unless the latched rd is 0; it then returns to IDLE.
REQ-016 Outside DONE, div_rd_wr_en_o, div_rd_addr_o and div_rd_data_o SHALL be 0.
REQ-017 div_start_i while div_busy_o=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-018 div_flush_i=1 in CALC or DONE SHALL return the block to IDLE on the next edge, with div_rd_wr_en_o forced to 0 in that cycle; flush in IDLE together with start SHALL reject the start.
REQ-019 div_busy_o SHALL be high in CALC and DONE, and low in IDLE.

Configuration
REQ-020 With macro EX_DIV_EARLY_OUT_EN defined, divisor zero and signed overflow SHALL skip CALC (IDLE -> DONE; wr_en one edge after start). Without the macro, these cases SHALL take the full 32 CALC cycles. Result values (REQ-013/014) SHALL be identical either way.

Reset
REQ-021 Asserting rst_n low SHALL, asynchronously, force state IDLE, counter 0, all latched operands 0, div_busy_o=0, div_rd_wr_en_o=0, div_rd_addr_o=0, div_rd_data_o=0.
REQ-022 Reset asserted mid-CALC SHALL discard the operation; no write SHALL occur after reset release.
REQ-023 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-024 DIV 20 / -3 (0x00000014, 0xFFFFFFFD), rd=5 -> wr_en=1 for one cycle, exactly 33 edges after the start edge, rd=5, data 0xFFFFFFFA; REM same operands -> data 0x00000002.
REQ-025 DIVU 0x12345678 / 0 -> data 0xFFFFFFFF; REMU -> 0x12345678; latency 1 edge with EX_DIV_EARLY_OUT_EN defined, 33 edges without it.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF -> data 0x80000000; REM -> 0x00000000.
REQ-027 Start DIVU 100/7, rd=3, then flush at CALC cycle 10 -> busy low next cycle, no wr_en ever; a new start of DIVU 100/7 then yields 0x0000000E.
REQ-028 Second start during busy with different operands -> ignored; first result is unchanged. rd=0 -> busy sequence normal, wr_en stays 0.
REQ-029 rst_n low at CALC cycle 15 -> all outputs 0 immediately; no write after release.
